iomem_burst_bridge: RTL and testbench

//  Sits directly downstream of the cpu top-level iomem port, between the core and the word-wide memory/peripheral bus.

---
 rtl/iomem_burst_bridge.sv | 163 ++++++++++++++++
 tb/tb_iomem_burst_bridge.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_burst_bridge.sv
// Splits one cache-line iomem request into 32-bit beats on a pipelined req/gnt/rvalid bus.
// Build option: define SKIP_EMPTY_BEATS_EN to drop write beats whose byte enables are all zero.
module iomem_burst_bridge #(
    parameter int XLEN            = 32,
    parameter int BLK_SIZE        = 128,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  iomem_valid,
    output logic                  iomem_ready,
    input  logic [BLK_SIZE/8-1:0] iomem_wstrb,
    input  logic [XLEN-1:0]       iomem_addr,
    input  logic [BLK_SIZE-1:0]   iomem_wdata,
    output logic [BLK_SIZE-1:0]   iomem_rdata,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [XLEN-1:0]       mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i
);

    localparam int NBEATS = BLK_SIZE / 32;
    localparam int BW     = $clog2(NBEATS);
    localparam int CW     = $clog2(NBEATS) + 1;
    localparam int LB     = BW + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t                        state;
    logic [CW-1:0]                 issue_cnt;
    logic [CW-1:0]                 resp_cnt;
    logic [CW-1:0]                 outstanding;
    logic [CW-1:0]                 beats_q;
    logic                          is_write_q;
    logic [XLEN-1:LB]              addr_q;
    logic [BLK_SIZE/8-1:0]         wstrb_q;
    logic [BLK_SIZE-1:0]           wdata_q;
    logic [NBEATS-1:0][BW-1:0]     order_q;
    logic [NBEATS-1:0][31:0]       line_q;

    logic [NBEATS-1:0][BW-1:0]     list_c;
    logic [CW-1:0]                 cnt_c;
    logic [NBEATS-1:0][31:0]       line_nxt;
    logic [BW-1:0]                 cur_beat;
    logic                          gnt_fire;
    logic                          rsp_fire;
    logic [CW-1:0]                 issue_nxt;
    logic [CW-1:0]                 resp_nxt;
    logic                          unused_addr_bits;

    assign unused_addr_bits = ^iomem_addr[LB-1:0];

    // Beat list for the incoming request, ascending beat order.
    always_comb begin
        cnt_c = CW'(NBEATS);
        for (int i = 0; i < NBEATS; i++) begin
            list_c[i] = BW'(i);
        end
`ifdef SKIP_EMPTY_BEATS_EN
        if (iomem_wstrb != '0) begin
            cnt_c = '0;
            for (int i = 0; i < NBEATS; i++) begin
                if (iomem_wstrb[4*i +: 4] != 4'h0) begin
                    list_c[cnt_c[BW-1:0]] = BW'(i);
                    cnt_c = cnt_c + CW'(1);
                end
            end
        end
`endif
    end

    assign cur_beat  = order_q[issue_cnt[BW-1:0]];
    assign mem_req_o = (state == ISSUE) && (outstanding < CW'(MAX_OUTSTANDING));
    assign gnt_fire  = mem_req_o && mem_gnt_i;
    assign rsp_fire  = mem_rvalid_i && ((state == ISSUE) || (state == DRAIN));
    assign issue_nxt = issue_cnt + CW'(gnt_fire);
    assign resp_nxt  = resp_cnt + CW'(rsp_fire);

    // Bus fields are only driven while a beat is being requested, so they read 0 otherwise.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            mem_we_o    = is_write_q;
            mem_be_o    = is_write_q ? wstrb_q[4*int'(cur_beat) +: 4] : 4'hF;
            mem_addr_o  = {addr_q, cur_beat, 2'b00};
            mem_wdata_o = wdata_q[32*int'(cur_beat) +: 32];
        end
    end

    always_comb begin
        line_nxt = line_q;
        if (rsp_fire && !is_write_q) begin
            line_nxt[resp_cnt[BW-1:0]] = mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            issue_cnt   <= '0;
            resp_cnt    <= '0;
            outstanding <= '0;
            beats_q     <= '0;
            is_write_q  <= 1'b0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            iomem_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (iomem_valid) begin
                        issue_cnt   <= '0;
                        resp_cnt    <= '0;
                        outstanding <= '0;
                        beats_q     <= cnt_c;
                        is_write_q  <= |iomem_wstrb;
                        state       <= ISSUE;
                    end
                end
                ISSUE, DRAIN: begin
                    issue_cnt <= issue_nxt;
                    resp_cnt  <= resp_nxt;
                    if (gnt_fire && !rsp_fire) begin
                        outstanding <= outstanding + CW'(1);
                    end else if (!gnt_fire && rsp_fire) begin
                        outstanding <= outstanding - CW'(1);
                    end
                    if ((issue_nxt == beats_q) && (resp_nxt == beats_q)) begin
                        state       <= RESP;
                        iomem_ready <= 1'b1;
                        if (!is_write_q) begin
                            iomem_rdata <= line_nxt;
                        end
                    end else if ((state == ISSUE) && (issue_nxt == beats_q)) begin
                        state <= DRAIN;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Request payload and the line being reassembled carry no reset; the control above gates their use.
    always_ff @(posedge clk_i) begin
        if ((state == IDLE) && iomem_valid) begin
            addr_q  <= iomem_addr[XLEN-1:LB];
            wstrb_q <= iomem_wstrb;
            wdata_q <= iomem_wdata;
            order_q <= list_c;
        end
        line_q <= line_nxt;
    end

endmodule

// File: tb/tb_iomem_burst_bridge.sv
// Randomized bench for iomem_burst_bridge: bus slave with latency/grant control plus a line-level reference model.
module tb_iomem_burst_bridge;

    localparam int MAXO = 2;
`ifdef SKIP_EMPTY_BEATS_EN
    localparam bit SKIP     = 1'b1;
    localparam int T2_BEATS = 1;
`else
    localparam bit SKIP     = 1'b0;
    localparam int T2_BEATS = 4;
`endif

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         iomem_valid;
    logic         iomem_ready;
    logic [15:0]  iomem_wstrb;
    logic [31:0]  iomem_addr;
    logic [127:0] iomem_wdata;
    logic [127:0] iomem_rdata;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [3:0]   mem_be_o;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic         mem_gnt_i;
    logic         mem_rvalid_i;
    logic [31:0]  mem_rdata_i;

    iomem_burst_bridge #(.XLEN(32), .BLK_SIZE(128), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    beat_t        exp_q[$];
    resp_t        resp_q[$];
    logic [31:0]  mem_w   [256];
    logic [31:0]  ref_mem [256];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           n_out = 0;
    int           txn_grants = 0;
    int           gnt_pct = 100;
    int           rv_lat = 1;
    int           stall_at = -1;
    int           stall_left = 0;
    bit           stray = 1'b0;
    bit           in_req = 1'b0;
    logic [127:0] last_read = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input string info);
        total++;
        bad++;
        $display("FAIL %s: %s", nm, info);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, iomem_ready, 0);
        chk({tag, "_rdata"}, iomem_rdata, 0);
        chk({tag, "_req"},   mem_req_o, 0);
        chk({tag, "_we"},    mem_we_o, 0);
        chk({tag, "_be"},    mem_be_o, 0);
        chk({tag, "_addr"},  mem_addr_o, 0);
        chk({tag, "_wdata"}, mem_wdata_o, 0);
    endtask

    // Bus slave plus per-cycle checks of everything visible on the beat bus.
    initial begin : bus
        logic        fire_g, fire_r, prev_stall, gwe;
        logic [3:0]  gbe;
        logic [31:0] ga, gwd;
        beat_t       cur, prev, e;
        resp_t       r;
        int          ix;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        prev_stall = 1'b0; prev = '0;
        forever begin
            @(negedge clk_i);
            fire_g = rst_ni && mem_req_o && mem_gnt_i;
            fire_r = rst_ni && mem_rvalid_i;
            cur = '{addr: mem_addr_o, we: mem_we_o, be: mem_be_o, wdata: mem_wdata_o};
            ga = mem_addr_o; gwe = mem_we_o; gbe = mem_be_o; gwd = mem_wdata_o;
            if (rst_ni) begin
                if (!in_req) chk("idle_ready", iomem_ready, 0);
                if (prev_stall) begin
                    chk("req_held", mem_req_o, 1);
                    chk("beat_held", cur, prev);
                end
                if (mem_req_o) chk("req_under_cap", (n_out < MAXO), 1);
                if (fire_g) begin
                    if (exp_q.size() == 0) fail("extra_beat", $sformatf("got=%h want=none", cur));
                    else begin
                        e = exp_q.pop_front();
                        chk("beat", cur, e);
                    end
                end
            end
            prev_stall = rst_ni && mem_req_o && !mem_gnt_i;
            prev = cur;
            @(posedge clk_i); #1;
            cyc++;
            if (!rst_ni) begin
                resp_q.delete(); n_out = 0; prev_stall = 1'b0;
                mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
                continue;
            end
            if (fire_r && resp_q.size() > 0) begin
                void'(resp_q.pop_front());
                n_out--;
            end
            if (fire_g) begin
                ix = int'(ga[9:2]);
                r.due = cyc + rv_lat - 1;
                r.data = mem_w[ix];
                if (gwe) for (int j = 0; j < 4; j++) if (gbe[j]) mem_w[ix][8*j +: 8] = gwd[8*j +: 8];
                resp_q.push_back(r);
                n_out++;
                txn_grants++;
            end
            mem_gnt_i = (int'($urandom_range(99)) < gnt_pct);
            if (stall_left > 0 && txn_grants == stall_at) begin
                mem_gnt_i = 1'b0;
                if (mem_req_o) stall_left--;
            end
            mem_rvalid_i = 1'b0;
            mem_rdata_i = $urandom();
            if (stray) begin
                mem_rvalid_i = 1'b1;
                stray = 1'b0;
            end else if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i = resp_q[0].data;
            end
        end
    end

    // Issue one line request from the reference model's view and check its completion.
    task automatic do_req(input logic [31:0] a, input logic [15:0] s, input logic [127:0] d, output int lat);
        logic [127:0] line;
        logic [3:0]   be;
        int           base;
        base = int'({a[9:4], 2'b00});
        line = '0;
        txn_grants = 0;
        for (int b = 0; b < 4; b++) begin
            be = (s == 16'h0) ? 4'hF : s[4*b +: 4];
            line[32*b +: 32] = ref_mem[base + b];
            if (SKIP && s != 16'h0 && be == 4'h0) continue;
            exp_q.push_back('{addr: {a[31:4], 2'(b), 2'b00}, we: (s != 16'h0), be: be, wdata: d[32*b +: 32]});
        end
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 4; j++)
                if (s[4*b + j]) ref_mem[base + b][8*j +: 8] = d[32*b + 8*j +: 8];
        iomem_addr = a; iomem_wstrb = s; iomem_wdata = d; iomem_valid = 1'b1; in_req = 1'b1;
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk_i); @(negedge clk_i); #1;
            if (iomem_ready) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) fail("ready_timeout", "got=no ready want=ready within 300 cycles");
        else begin
            chk("beats_left", exp_q.size(), 0);
            chk("resp_left", resp_q.size(), 0);
            if (s == 16'h0) last_read = line;
            chk("rdata", iomem_rdata, last_read);
        end
        @(posedge clk_i); #1;
        chk("ready_pulse", iomem_ready, 0);
        iomem_valid = 1'b0; in_req = 1'b0;
        exp_q.delete();
    endtask

    initial begin : main
        int           lat, lat2;
        bit           got;
        logic [15:0]  s;
        logic [127:0] d;
        iomem_valid = 1'b0; iomem_wstrb = '0; iomem_addr = '0; iomem_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem_w[i] = $urandom();
            ref_mem[i] = mem_w[i];
        end
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        #1 chk_zero("reset");
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Read of line 0x8000_0010 with a zero-wait bus.
        mem_w[4] = 32'h11; mem_w[5] = 32'h22; mem_w[6] = 32'h33; mem_w[7] = 32'h44;
        ref_mem[4] = 32'h11; ref_mem[5] = 32'h22; ref_mem[6] = 32'h33; ref_mem[7] = 32'h44;
        gnt_pct = 100; rv_lat = 1;
        do_req(32'h8000_0014, 16'h0, '0, lat);
        chk("t1_latency", lat, 6);
        chk("t1_rdata", iomem_rdata, 128'h00000044_00000033_00000022_00000011);
        chk("t1_beats", txn_grants, 4);

        // Sparse write: only beat 1 has byte enables.
        do_req(32'h0000_0100, 16'h00F0, {64'h0123_4567_89AB_CDEF, 32'hDEAD_BEEF, 32'h55AA_55AA}, lat);
        chk("t2_beats", txn_grants, T2_BEATS);
        chk("t2_mem", mem_w[65], 32'hDEAD_BEEF);
        chk("t2_rdata_kept", iomem_rdata, 128'h00000044_00000033_00000022_00000011);

        // Grant withheld for three cycles on beat 1.
        stall_at = 1; stall_left = 3;
        do_req(32'h0000_0230, 16'h0, '0, lat);
        chk("t3_latency", lat, 9);
        stall_at = -1; stall_left = 0;

        // Slow responder against the outstanding cap.
        rv_lat = 5;
        do_req(32'h0000_0340, 16'h0, '0, lat);
        do_req(32'h0000_0340, 16'hFFFF, {$urandom(), $urandom(), $urandom(), $urandom()}, lat);
        do_req(32'h0000_0340, 16'h0, '0, lat);

        // Reset in the middle of a read burst.
        rv_lat = 3;
        iomem_addr = 32'h8000_0040; iomem_wstrb = '0; iomem_wdata = '0;
        iomem_valid = 1'b1; in_req = 1'b1; txn_grants = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 32'h8000_0040 + 32'(4*i), we: 1'b0, be: 4'hF, wdata: '0});
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i); #2;
            if (txn_grants >= 3) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail("t5_grant_timeout", "got=<3 grants want=3 grants");
        rst_ni = 1'b0;
        #1 chk_zero("t5_reset");
        iomem_valid = 1'b0; in_req = 1'b0; exp_q.delete();
        @(posedge clk_i); @(posedge clk_i);
        #3 rst_ni = 1'b1;
        last_read = '0;
        @(posedge clk_i); #2;
        stray = 1'b1;
        repeat (4) begin
            @(negedge clk_i); #1;
            chk("t5_idle_req", mem_req_o, 0);
        end
        @(posedge clk_i); #1;
        rv_lat = 1;
        do_req(32'h8000_0040, 16'h0, '0, lat);
        chk("t5_after_latency", lat, 6);

        // Back-to-back requests: second presented in the cycle after the first completion.
        do_req(32'h0000_0050, 16'h0, '0, lat);
        do_req(32'h0000_0060, 16'h000F, {96'h0, 32'hCAFE_F00D}, lat2);
        chk("t6_lat_first", lat, 6);
        chk("t6_lat_second", lat2, 6);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(2))
                0: gnt_pct = 100;
                1: gnt_pct = 50;
                default: gnt_pct = 25;
            endcase
            rv_lat = int'($urandom_range(5, 1));
            if ($urandom_range(2) == 0) s = 16'h0;
            else begin
                for (int n = 0; n < 4; n++)
                    s[4*n +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
                if (s == 16'h0) s[3:0] = 4'hF;
            end
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            do_req($urandom(), s, d, lat);
            repeat ($urandom_range(2)) begin
                @(posedge clk_i); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got=still running want=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
